// File: rtl/inp_encoder_if.sv
// Bundle of controller-side inputs and encoded outputs for inp_encoder.
// The master side drives keyboard, joysticks and video timing.
// The slave side is the encoder that produces the cabinet input words.
interface inp_encoder_if;
  logic [10:0] ps2_key;
  logic [15:0] joy1;
  logic [15:0] joy2;
  logic        vblank;
  logic        cocktail;
  logic [5:0]  inp0;
  logic [5:0]  inp1;
  logic [2:0]  inp2;

  modport master (
    output ps2_key, joy1, joy2, vblank, cocktail,
    input  inp0, inp1, inp2
  );

  modport slave (
    input  ps2_key, joy1, joy2, vblank, cocktail,
    output inp0, inp1, inp2
  );
endinterface

// File: rtl/inp_encoder.sv
// Merges PS/2 keyboard state and two joysticks into the arcade input words.
// Coin requests are turned into a fixed-length pulse counted in vblank frames.
// A held coin produces exactly one pulse; it must be released before the next one.
module inp_encoder #(
  parameter int COIN_FRAMES = 3
) (
  input  logic         clk_sys,
  input  logic         reset,
  inp_encoder_if.slave bus
);

  localparam int NUM_KEYS = 18;
  localparam int K_UP = 0, K_DOWN = 1, K_LEFT = 2, K_RIGHT = 3;
  localparam int K_TRIG1 = 4, K_TRIG2 = 5, K_F1 = 6, K_F2 = 7;
  localparam int K_START1 = 8, K_START2 = 9, K_COIN1 = 10, K_COIN2 = 11;
  localparam int K_UP2 = 12, K_DOWN2 = 13, K_LEFT2 = 14, K_RIGHT2 = 15;
  localparam int K_TRIG1_2 = 16, K_TRIG2_2 = 17;
  localparam logic [3:0] COIN_LOAD = 4'(COIN_FRAMES);

  typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE} coin_state_t;

  logic                old_tgl_reg;
  logic [NUM_KEYS-1:0] key_reg;
  logic [NUM_KEYS-1:0] key_hit;
  logic                key_event;
  logic [5:0]          p1_own, p2_term, p1_term;
  logic                start1, start2, coin_raw;
  logic [5:0]          inp0_reg, inp1_reg;
  logic [1:0]          start_reg;
  logic                vb_sync1_reg, vb_sync2_reg, vb_edge_reg;
  logic                frame_tick;
  logic                coin_d_reg;
  coin_state_t         state_reg, state_next;
  logic [3:0]          count_reg, count_next;
  logic                unused_bits;

  assign unused_bits = ^{bus.joy1[15:9], bus.joy2[15:9]};
  assign key_event   = bus.ps2_key[10] ^ old_tgl_reg;

  // Map a scancode to the single key latch it controls; E0-prefixed arrows alias the plain ones.
  always_comb begin
    key_hit = '0;
    case (bus.ps2_key[8:0])
      9'h075, 9'h175: key_hit[K_UP]     = 1'b1;
      9'h072, 9'h172: key_hit[K_DOWN]   = 1'b1;
      9'h06B, 9'h16B: key_hit[K_LEFT]   = 1'b1;
      9'h074, 9'h174: key_hit[K_RIGHT]  = 1'b1;
      9'h029:         key_hit[K_TRIG1]  = 1'b1;
      9'h014:         key_hit[K_TRIG2]  = 1'b1;
      9'h005:         key_hit[K_F1]     = 1'b1;
      9'h006:         key_hit[K_F2]     = 1'b1;
      9'h016:         key_hit[K_START1] = 1'b1;
      9'h01E:         key_hit[K_START2] = 1'b1;
      9'h02E:         key_hit[K_COIN1]  = 1'b1;
      9'h036:         key_hit[K_COIN2]  = 1'b1;
      9'h02D:         key_hit[K_UP2]    = 1'b1;
      9'h02B:         key_hit[K_DOWN2]  = 1'b1;
      9'h023:         key_hit[K_LEFT2]  = 1'b1;
      9'h034:         key_hit[K_RIGHT2] = 1'b1;
      9'h01C:         key_hit[K_TRIG1_2] = 1'b1;
      9'h01B:         key_hit[K_TRIG2_2] = 1'b1;
      default: ;
    endcase
  end

  // Track the toggle bit; reload it during reset so release never looks like an event.
  always_ff @(posedge clk_sys) begin
    old_tgl_reg <= bus.ps2_key[10];
  end

  // Each key latch follows the pressed flag of the last event that addressed it.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      key_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (key_event && key_hit[i]) key_reg[i] <= bus.ps2_key[9];
      end
    end
  end

  // Combine latches and joysticks; output order is {Trig2,Trig1,Left,Down,Right,Up}.
  always_comb begin
    p2_term = {key_reg[K_TRIG2_2] | bus.joy2[5], key_reg[K_TRIG1_2] | bus.joy2[4],
               key_reg[K_LEFT2]   | bus.joy2[1], key_reg[K_DOWN2]   | bus.joy2[2],
               key_reg[K_RIGHT2]  | bus.joy2[0], key_reg[K_UP2]     | bus.joy2[3]};
    p1_own  = {key_reg[K_TRIG2] | bus.joy1[5], key_reg[K_TRIG1] | bus.joy1[4],
               key_reg[K_LEFT]  | bus.joy1[1], key_reg[K_DOWN]  | bus.joy1[2],
               key_reg[K_RIGHT] | bus.joy1[0], key_reg[K_UP]    | bus.joy1[3]};
    p1_term = p1_own | (bus.cocktail ? 6'd0 : p2_term);
    start1  = key_reg[K_F1] | key_reg[K_START1] | bus.joy1[6] | bus.joy2[6];
    start2  = key_reg[K_F2] | key_reg[K_START2] | bus.joy1[7] | bus.joy2[7];
    coin_raw = key_reg[K_F1] | key_reg[K_F2] | key_reg[K_COIN1] | key_reg[K_COIN2]
             | bus.joy1[8] | bus.joy2[8];
  end

  // Register the player and start outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      inp0_reg  <= '0;
      inp1_reg  <= '0;
      start_reg <= '0;
    end else begin
      inp0_reg  <= p1_term;
      inp1_reg  <= p2_term;
      start_reg <= {start2, start1};
    end
  end

  // Bring vblank into clk_sys and keep one extra stage for rising-edge detection.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      vb_sync1_reg <= 1'b0;
      vb_sync2_reg <= 1'b0;
      vb_edge_reg  <= 1'b0;
    end else begin
      vb_sync1_reg <= bus.vblank;
      vb_sync2_reg <= vb_sync1_reg;
      vb_edge_reg  <= vb_sync2_reg;
    end
  end

  assign frame_tick = vb_sync2_reg & ~vb_edge_reg;

  // Coin edge history; presetting to 1 means a coin held through reset is not a new press.
  always_ff @(posedge clk_sys) begin
    if (reset) coin_d_reg <= 1'b1;
    else       coin_d_reg <= coin_raw;
  end

  // Coin pulse state and frame counter.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // Coin pulse sequencing: start on a fresh press, end after COIN_FRAMES ticks, wait for release.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (coin_raw && !coin_d_reg) begin
          state_next = ACTIVE;
          count_next = COIN_LOAD;
        end
      end
      ACTIVE: begin
        if (frame_tick) begin
          count_next = count_reg - 4'd1;
          if (count_reg == 4'd1) state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (!coin_raw) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  assign bus.inp0 = inp0_reg;
  assign bus.inp1 = inp1_reg;
  assign bus.inp2 = {state_reg == ACTIVE, start_reg};

endmodule

// File: tb/tb_inp_encoder.sv
// Scoreboard bench for inp_encoder: a behavioural model predicts the outputs
// after every clock edge, and a monitor compares them on the falling edge.
module tb_inp_encoder;
  localparam int COIN_FRAMES = 3;

  logic clk_sys = 1'b0;
  logic reset;
  inp_encoder_if bus();

  inp_encoder #(.COIN_FRAMES(COIN_FRAMES)) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [5:0] i0;
    logic [5:0] i1;
    logic [2:0] i2;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model state: which named controls are held, plus coin and vblank bookkeeping.
  bit m_held[string];
  bit m_old_tgl;
  bit vb_h[3];
  bit m_prev_coin;
  bit m_pulse;
  int m_ticks;
  bit m_lock;
  int vb_phase = 0;

  function automatic string key_name(logic [8:0] code);
    if (code[7:0] == 8'h75) return "up";
    if (code[7:0] == 8'h72) return "down";
    if (code[7:0] == 8'h6B) return "left";
    if (code[7:0] == 8'h74) return "right";
    case (code)
      9'h029: return "trig1";
      9'h014: return "trig2";
      9'h005: return "f1";
      9'h006: return "f2";
      9'h016: return "start1";
      9'h01E: return "start2";
      9'h02E: return "coin1";
      9'h036: return "coin2";
      9'h02D: return "up2";
      9'h02B: return "down2";
      9'h023: return "left2";
      9'h034: return "right2";
      9'h01C: return "trig1_2";
      9'h01B: return "trig2_2";
      default: return "";
    endcase
  endfunction

  function automatic bit held(string n);
    return m_held.exists(n) ? m_held[n] : 1'b0;
  endfunction

  // Predict the outputs visible after this clock edge from the inputs present at it.
  function automatic void model_edge();
    exp_t e;
    bit [5:0] p1, p2;
    bit s1, s2, craw, tick;
    string n;
    if (reset) begin
      m_held.delete();
      m_old_tgl   = bus.ps2_key[10];
      vb_h[0] = 0; vb_h[1] = 0; vb_h[2] = 0;
      m_prev_coin = 1'b1;
      m_pulse = 0; m_ticks = 0; m_lock = 0;
      e = '0;
    end else begin
      p2 = {held("trig2_2") | bus.joy2[5], held("trig1_2") | bus.joy2[4],
            held("left2") | bus.joy2[1], held("down2") | bus.joy2[2],
            held("right2") | bus.joy2[0], held("up2") | bus.joy2[3]};
      p1 = {held("trig2") | bus.joy1[5], held("trig1") | bus.joy1[4],
            held("left") | bus.joy1[1], held("down") | bus.joy1[2],
            held("right") | bus.joy1[0], held("up") | bus.joy1[3]};
      if (!bus.cocktail) p1 = p1 | p2;
      s1 = held("f1") | held("start1") | bus.joy1[6] | bus.joy2[6];
      s2 = held("f2") | held("start2") | bus.joy1[7] | bus.joy2[7];
      craw = held("f1") | held("f2") | held("coin1") | held("coin2") | bus.joy1[8] | bus.joy2[8];
      tick = vb_h[1] & ~vb_h[2];
      if (m_pulse) begin
        if (tick) begin
          m_ticks++;
          if (m_ticks == COIN_FRAMES) begin
            m_pulse = 0;
            m_lock  = 1;
          end
        end
      end else if (m_lock) begin
        if (!craw) m_lock = 0;
      end else if (craw && !m_prev_coin) begin
        m_pulse = 1;
        m_ticks = 0;
      end
      m_prev_coin = craw;
      e.i0 = p1;
      e.i1 = p2;
      e.i2 = {m_pulse, s2, s1};
      if (bus.ps2_key[10] != m_old_tgl) begin
        n = key_name(bus.ps2_key[8:0]);
        if (n != "") m_held[n] = bus.ps2_key[9];
      end
      m_old_tgl = bus.ps2_key[10];
      vb_h[2] = vb_h[1];
      vb_h[1] = vb_h[0];
      vb_h[0] = bus.vblank;
    end
    exp_q.push_back(e);
  endfunction

  // Monitor: compare each predicted output set on the falling edge after its clock edge.
  always @(negedge clk_sys) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.inp0 !== e.i0) begin
        n_bad++;
        $display("FAIL inp0 t=%0t got %b want %b", $time, bus.inp0, e.i0);
      end
      n_cmp++;
      if (bus.inp1 !== e.i1) begin
        n_bad++;
        $display("FAIL inp1 t=%0t got %b want %b", $time, bus.inp1, e.i1);
      end
      n_cmp++;
      if (bus.inp2 !== e.i2) begin
        n_bad++;
        $display("FAIL inp2 t=%0t got %b want %b", $time, bus.inp2, e.i2);
      end
    end
  end

  // One clock: set vblank phase, let the edge happen, record the prediction.
  task automatic step();
    bus.vblank = ((vb_phase % 24) < 4);
    vb_phase++;
    @(posedge clk_sys);
    model_edge();
    @(negedge clk_sys);
  endtask

  task automatic key(input bit pressed, input logic [8:0] code);
    bus.ps2_key = {~bus.ps2_key[10], pressed, code};
    step();
  endtask

  logic [8:0] codes [0:23] = '{9'h075, 9'h175, 9'h072, 9'h172, 9'h06B, 9'h16B, 9'h074,
                              9'h174, 9'h029, 9'h014, 9'h005, 9'h006, 9'h016, 9'h01E,
                              9'h02E, 9'h036, 9'h02D, 9'h02B, 9'h023, 9'h034, 9'h01C,
                              9'h01B, 9'h01D, 9'h129};

  initial begin
    int r;
    logic [8:0] c;
    bus.ps2_key  = '0;
    bus.joy1     = '0;
    bus.joy2     = '0;
    bus.vblank   = 1'b0;
    bus.cocktail = 1'b0;
    reset = 1'b1;
    @(negedge clk_sys);
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();

    // Extended up key press and release, two-edge latency.
    key(1'b1, 9'h175);
    repeat (2) step();
    key(1'b0, 9'h175);
    repeat (3) step();

    // P2 trigger shared into P1 only when not in cocktail mode.
    bus.joy2[4] = 1'b1;
    repeat (2) step();
    bus.cocktail = 1'b1;
    repeat (2) step();
    bus.joy2[4] = 1'b0;
    bus.cocktail = 1'b0;
    step();

    // Unlisted code, then a code change without a toggle.
    key(1'b1, 9'h01D);
    bus.ps2_key[9:0] = {1'b1, 9'h075};
    repeat (3) step();

    // Coin held for ten frames, released, pressed again.
    bus.joy1[8] = 1'b1;
    repeat (240) step();
    bus.joy1[8] = 1'b0;
    repeat (30) step();
    bus.joy1[8] = 1'b1;
    repeat (100) step();
    bus.joy1[8] = 1'b0;
    repeat (5) step();

    // Reset during an active coin pulse with coin held.
    bus.joy1[8] = 1'b1;
    repeat (5) step();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    repeat (60) step();
    bus.joy1[8] = 1'b0;
    repeat (5) step();
    bus.joy1[8] = 1'b1;
    repeat (80) step();
    bus.joy1[8] = 1'b0;
    repeat (5) step();

    // Randomized mix of key events, joystick changes, mode flips and resets.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      if (r < 30) begin
        c = codes[$urandom_range(0, 23)];
        bus.ps2_key = {~bus.ps2_key[10], 1'($urandom_range(0, 1)), c};
      end else if (r < 36) begin
        bus.ps2_key[9:0] = 10'($urandom);
      end else if (r < 60) begin
        bus.joy1[$urandom_range(0, 15)] ^= 1'b1;
      end else if (r < 84) begin
        bus.joy2[$urandom_range(0, 15)] ^= 1'b1;
      end else if (r < 88) begin
        bus.cocktail = ~bus.cocktail;
      end
      reset = (r == 199);
      step();
    end
    reset = 1'b0;
    repeat (2) step();
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/inp_encoder.md
INP_ENCODER -- requirements
Module: inp_encoder

Interface
REQ-001 SHALL have parameter: COIN_FRAMES, default 3, coin pulse length in vblank rising edges; legal 1..15, held in a 4-bit counter.
REQ-002 SHALL have port: clk_sys  in  1  system clock (48 MHz); all logic on its rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: ps2_key  in  11  [10] toggle, [9] pressed, [8:0] extended scancode.
REQ-005 SHALL have port: joy1  in  16  player-1 joystick, active-high: [0]R [1]L [2]D [3]U [4]Trig1 [5]Trig2 [6]Start1 [7]Start2 [8]Coin.
REQ-006 SHALL have port: joy2  in  16  player-2 joystick, same bit map.
REQ-007 SHALL have port: vblank  in  1  video vertical blank (PCLK domain, level stable for many clk_sys cycles).
REQ-008 SHALL have port: cocktail  in  1  0 = P2 controls also OR'd into P1; 1 = separate.
REQ-009 SHALL have port: inp0  out  6  {Trig2,Trig1,Left,Down,Right,Up} P1, active-high.
REQ-010 SHALL have port: inp1  out  6  same order, P2.
REQ-011 SHALL have port: inp2  out  3  {Coin,Start2,Start1}.

Function
REQ-012 SHALL register ps2_key[10] into old_tgl every cycle; a key event SHALL be the cycle where ps2_key[10] != old_tgl.
REQ-013 On a key event, the latch selected by ps2_key[8:0] SHALL load ps2_key[9]; unlisted codes SHALL be ignored; at most one latch SHALL change per event.
REQ-014 SHALL decode: X75 up, X72 down, X6B left, X74 right (X = either prefix); 029 trig1, 014 trig2, 005 F1, 006 F2.
REQ-015 SHALL decode P2/MAME codes: 016 start1, 01E start2, 02E coin1, 036 coin2, 02D up2, 02B down2, 023 left2, 034 right2, 01C trig1_2, 01B trig2_2.
REQ-016 P2 terms SHALL be key latch OR joy2 bit; P1 terms SHALL be key latch OR joy1 bit OR (cocktail ? 0 : P2 term).
REQ-017 Start1 SHALL be F1|start1 latch|joy1[6]|joy2[6]; Start2 SHALL be F2|start2 latch|joy1[7]|joy2[7].
REQ-018 Opposing directions both asserted SHALL pass through unchanged (no SOCD cleaning).
REQ-019 coin_raw SHALL be F1|F2|coin1|coin2 latch|joy1[8]|joy2[8].
REQ-020 vblank SHALL pass two flops (sync) plus one edge flop; frame_tick SHALL be one cycle on synced vblank 0->1.
REQ-021 Coin FSM states: IDLE, ACTIVE, RELEASE.
REQ-022 IDLE->ACTIVE on coin_raw rising edge (coin_raw=1, coin_d=0); counter loads COIN_FRAMES.
REQ-023 ACTIVE: counter decrements on frame_tick; on frame_tick with counter==1, go RELEASE.
REQ-024 RELEASE->IDLE when coin_raw=0; RELEASE held while coin_raw=1 (no auto-repeat).
REQ-025 inp2[2] SHALL be 1 exactly while FSM is ACTIVE; new coin edges during ACTIVE or RELEASE SHALL be ignored.
REQ-026 inp0/inp1/inp2[1:0] SHALL be registered: joystick change before edge k visible after edge k.
REQ-027 Key event at edge k SHALL update the latch at k and the output after edge k+1 (2-edge latency).
REQ-028 coin_raw rising at edge k SHALL assert inp2[2] after edge k+1.
REQ-029 Simultaneous key event and joystick change on the same bit SHALL OR both; no priority.

Reset
REQ-030 On reset: all key latches 0, inp0/inp1/inp2 = 0, FSM IDLE, counter 0, vblank sync/edge flops 0.
REQ-031 On reset: old_tgl SHALL load ps2_key[10] (no spurious event on release); coin_d SHALL load 1 (coin held through reset gives no pulse until released and re-pressed).
REQ-032 Reset mid-ACTIVE SHALL drop inp2[2] next edge and abort the pulse.

Verification
REQ-033 Toggle ps2_key[10] with {pressed=1,code=0x175} -> inp0 = 6'b000001 two edges later; repeat with pressed=0 -> inp0 = 0.
REQ-034 cocktail=0, joy2[4]=1 -> inp0[4]=1 and inp1[4]=1 after 1 edge; cocktail=1 -> inp0[4]=0, inp1[4]=1.
REQ-035 COIN_FRAMES=3, joy1[8] held 10 frames -> inp2[2] high from 1 edge after press until 3rd vblank rise; no second pulse until release+re-press.
REQ-036 Unlisted code 0x01D event, and event with ps2_key[10] unchanged -> outputs unchanged.
REQ-037 Reset asserted in ACTIVE with coin held, then released -> inp2 = 0 and stays 0 until coin drops and rises again.
